// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback (req0)
// and the multi-cycle unit (req1), registering the winning write for one cycle.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              sel,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              zero_drop
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    W0,
    W1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              zd_q, zd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              grant0, grant1;

  // req1 wins when it is alone or once it has lost STARVE_LIMIT contended cycles.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !hold) begin
      if (req1_valid && (!req0_valid || (cnt_q >= LIMIT))) begin
        grant1 = 1'b1;
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    zd_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (grant0) begin
      state_d = W0;
      sel_d   = 1'b0;
      addr_d  = req0_addr;
      data_d  = req0_data;
      zd_d    = (req0_addr == '0);
    end else if (grant1) begin
      state_d = W1;
      sel_d   = 1'b1;
      addr_d  = req1_addr;
      data_d  = req1_data;
      zd_d    = (req1_addr == '0);
    end

    // Counter only tracks contended losses; it is frozen while arbitration is held.
    if (!hold) begin
      if (!req1_valid || grant1) begin
        cnt_d = 4'd0;
      end else if (grant0 && (cnt_q < LIMIT)) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 1'b0;
      zd_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      zd_q    <= zd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // A write already in the output register is suppressed if reset arrives before it lands.
  assign we        = (state_q != IDLE) && !zd_q && !rst;
  assign sel       = sel_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign zero_drop = zd_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Table-driven bench for wb_port_arbiter: per-vector ready checks plus a scoreboard
// of the registered write expected one cycle later.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req0_ready, req1_ready, sel, we, zero_drop;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        zReady0, zReady1, zSel, zWe, zZeroDrop;
  logic [4:0]  zWrAddr;
  logic [31:0] zWrData;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        hold;
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        er0;
    logic        er1;
  } vec_t;

  typedef struct {
    logic        we;
    logic        sel;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        zd;
  } out_t;

  vec_t vecs[$];
  out_t expQ[$];
  logic        mSel;
  logic [4:0]  mAddr;
  logic [31:0] mData;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .sel(sel), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .zero_drop(zero_drop)
  );

  // Same inputs, STARVE_LIMIT=0: req1 must win every contended cycle.
  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(0)) dutZero (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(zReady0),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(zReady1),
    .sel(zSel), .we(zWe), .wr_addr(zWrAddr), .wr_data(zWrData), .zero_drop(zZeroDrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic h, logic v0, logic [4:0] a0, logic [31:0] d0,
                              logic v1, logic [4:0] a1, logic [31:0] d1, logic er0, logic er1);
    vec_t v;
    v.rst = r; v.hold = h; v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1; v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    out_t e;
    out_t got;
    logic zExp0, zExp1;
    rst        = v.rst;
    hold       = v.hold;
    req0_valid = v.v0;
    req0_addr  = v.a0;
    req0_data  = v.d0;
    req1_valid = v.v1;
    req1_addr  = v.a1;
    req1_data  = v.d1;
    #1;
    checkOutput($sformatf("ready v%0d", idx), {62'd0, req0_ready, req1_ready}, {62'd0, v.er0, v.er1});
    zExp1 = !v.rst && !v.hold && v.v1;
    zExp0 = !v.rst && !v.hold && v.v0 && !v.v1;
    checkOutput($sformatf("limit0 ready v%0d", idx), {62'd0, zReady0, zReady1}, {62'd0, zExp0, zExp1});
    if (v.rst) checkOutput($sformatf("we during rst v%0d", idx), {63'd0, we}, 64'd0);

    e.we = 1'b0;
    e.zd = 1'b0;
    if (v.rst) begin
      mSel = 1'b0; mAddr = '0; mData = '0;
    end else if (v.er0) begin
      mSel = 1'b0; mAddr = v.a0; mData = v.d0;
      e.we = (v.a0 != 0); e.zd = (v.a0 == 0);
    end else if (v.er1) begin
      mSel = 1'b1; mAddr = v.a1; mData = v.d1;
      e.we = (v.a1 != 0); e.zd = (v.a1 == 0);
    end
    e.sel = mSel; e.addr = mAddr; e.data = mData;
    expQ.push_back(e);

    @(posedge clk);
    #1;
    got = expQ.pop_front();
    checkOutput($sformatf("wb out v%0d", idx),
                {24'd0, we, sel, wr_addr, wr_data, zero_drop},
                {24'd0, got.we, got.sel, got.addr, got.data, got.zd});
  endtask

  initial begin
    logic [31:0] dA, dB;
    dA = 32'hA0A0_0004;
    dB = 32'hB0B0_0007;
    rst = 1'b1; hold = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    mSel = 1'b0; mAddr = '0; mData = '0;

    // Reset with both requesters valid, then solo transfers and an idle cycle.
    vecs.push_back(mk(1, 0, 1, 5'd3, 32'h1, 1, 5'd9, 32'h2, 0, 0));
    vecs.push_back(mk(1, 0, 1, 5'd3, 32'h1, 1, 5'd9, 32'h2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0, 1, 5'd9, 32'hDEAD_BEEF, 0, 1));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5'd3, 32'h1111_0003, 0, 5'd0, 32'h0, 1, 0));
    // Continuous contention: 0,0,0,0,1 twice.
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(0, 0, 1, 5'd4, dA, 1, 5'd7, dB, (i % 5) != 4, (i % 5) == 4));
    end
    // Write to $0 is accepted but dropped.
    vecs.push_back(mk(0, 0, 1, 5'd0, 32'h0000_CAFE, 0, 5'd0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0));
    // Two contended losses, hold for 3 cycles, then the count resumes from 2.
    vecs.push_back(mk(0, 0, 1, 5'd4, dA, 1, 5'd7, dB, 1, 0));
    vecs.push_back(mk(0, 0, 1, 5'd4, dA, 1, 5'd7, dB, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 1, 5'd4, dA, 1, 5'd7, dB, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5'd4, dA, 1, 5'd7, dB, 1, 0));
    vecs.push_back(mk(0, 0, 1, 5'd4, dA, 1, 5'd7, dB, 1, 0));
    vecs.push_back(mk(0, 0, 1, 5'd4, dA, 1, 5'd7, dB, 0, 1));
    // Hold after a req1 write: sel must stay 1.
    vecs.push_back(mk(0, 1, 1, 5'd4, dA, 0, 5'd0, 32'h0, 0, 0));

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Counter at 3, then reset: contention must restart from zero.
    for (int i = 0; i < 3; i++) applyStimulus(mk(0, 0, 1, 5'd5, dA, 1, 5'd6, dB, 1, 0), 100 + i);
    applyStimulus(mk(1, 0, 1, 5'd5, dA, 1, 5'd6, dB, 0, 0), 103);
    for (int i = 0; i < 5; i++) applyStimulus(mk(0, 0, 1, 5'd5, dA, 1, 5'd6, dB, i != 4, i == 4), 104 + i);

    // Reset arriving the cycle after a req1 accept drops the in-flight write.
    applyStimulus(mk(0, 0, 0, 5'd0, 32'h0, 1, 5'd12, 32'h1234_5678, 0, 1), 110);
    applyStimulus(mk(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0), 111);
    applyStimulus(mk(0, 0, 1, 5'd5, dA, 1, 5'd6, dB, 1, 0), 112);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
